// File: rtl/ext_spi_master_if.sv
// Request/response channel between the controller fabric and ext_spi_master.
// The fabric side uses the master modport; the SPI engine uses the slave modport.
interface ext_spi_master_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_reg;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output req_valid,
        output req_reg,
        output req_data,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_data,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/ext_spi_master.sv
// SPI master for the CPLD 0xDF port-emulation slave: one 16-bit frame per request,
// returns the bus snapshot and flags a bad 0xEE marker.
module ext_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ext_spi_master_if.slave         bus,
    output logic                    o_busy,
    output logic                    o_sck,
    output logic                    o_ss_n,
    output logic                    o_mosi,
    input  logic                    i_miso
);

    localparam int unsigned CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [7:0]    MARKER   = 8'hEE;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StGap
    } state_e;

    state_e         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [3:0]     r_bit, w_bit_nxt;
    logic [15:0]    r_tx, w_tx_nxt;
    logic [15:0]    r_rx, w_rx_nxt;
    logic           r_sck, w_sck_nxt;
    logic           r_ss_n, w_ss_n_nxt;
    logic           r_mosi, w_mosi_nxt;
    logic           r_ready, w_ready_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_rsp_valid, w_rsp_valid_nxt;
    logic [7:0]     r_rsp_data, w_rsp_data_nxt;
    logic           r_rsp_err, w_rsp_err_nxt;

    logic [15:0]    w_word;
    logic           w_div_done;
    logic           w_gap_done;

    assign w_word     = {5'b00000, bus.req_reg, bus.req_data};
    assign w_div_done = (r_cnt == DIV_LAST);
    assign w_gap_done = (r_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_sck       <= 1'b0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_tx        <= w_tx_nxt;
            r_rx        <= w_rx_nxt;
            r_sck       <= w_sck_nxt;
            r_ss_n      <= w_ss_n_nxt;
            r_mosi      <= w_mosi_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_nxt       = r_bit;
        w_tx_nxt        = r_tx;
        w_rx_nxt        = r_rx;
        w_sck_nxt       = r_sck;
        w_ss_n_nxt      = r_ss_n;
        w_mosi_nxt      = r_mosi;
        w_ready_nxt     = r_ready;
        w_busy_nxt      = r_busy;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;

        unique case (r_state)
            StIdle: begin
                if (bus.req_valid) begin
                    // r_tx holds the bits still to send, MSB-aligned
                    w_state_nxt = StSetup;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = {w_word[14:0], 1'b0};
                    w_mosi_nxt  = w_word[15];
                    w_ss_n_nxt  = 1'b0;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            StSetup: begin
                if (w_div_done) begin
                    w_state_nxt = StHigh;
                    w_cnt_nxt   = '0;
                    w_sck_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StHigh: begin
                if (w_div_done) begin
                    w_state_nxt = StLow;
                    w_cnt_nxt   = '0;
                    w_sck_nxt   = 1'b0;
                    w_rx_nxt    = {r_rx[14:0], i_miso};
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StLow: begin
                if (w_div_done) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 4'd15) begin
                        w_state_nxt     = StGap;
                        w_ss_n_nxt      = 1'b1;
                        w_mosi_nxt      = 1'b0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = r_rx[7:0];
                        w_rsp_err_nxt   = (r_rx[15:8] != MARKER);
                    end else begin
                        // next bit goes out with the rising edge
                        w_state_nxt = StHigh;
                        w_bit_nxt   = r_bit + 4'd1;
                        w_sck_nxt   = 1'b1;
                        w_mosi_nxt  = r_tx[15];
                        w_tx_nxt    = {r_tx[14:0], 1'b0};
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StGap: begin
                if (w_gap_done) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
                w_sck_nxt   = 1'b0;
                w_ss_n_nxt  = 1'b1;
                w_mosi_nxt  = 1'b0;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign o_busy        = r_busy;
    assign o_sck         = r_sck;
    assign o_ss_n        = r_ss_n;
    assign o_mosi        = r_mosi;

endmodule

// File: tb/tb_ext_spi_master.sv
// Directed bench for ext_spi_master: CLK_DIV=2 and CLK_DIV=1 instances share one
// behavioural CPLD slave model through a select mux.
module tb_ext_spi_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_reg = 3'd0;
    logic [7:0] req_data = 8'd0;

    logic busy_a, sck_a, ss_n_a, mosi_a;
    logic busy_b, sck_b, ss_n_b, mosi_b;
    logic miso;

    ext_spi_master_if u_if_a ();
    ext_spi_master_if u_if_b ();

    assign u_if_a.req_valid = req_valid & ~sel;
    assign u_if_a.req_reg   = req_reg;
    assign u_if_a.req_data  = req_data;
    assign u_if_b.req_valid = req_valid & sel;
    assign u_if_b.req_reg   = req_reg;
    assign u_if_b.req_data  = req_data;

    ext_spi_master #(.CLK_DIV(2), .GAP(4)) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (u_if_a.slave),
        .o_busy (busy_a),
        .o_sck  (sck_a),
        .o_ss_n (ss_n_a),
        .o_mosi (mosi_a),
        .i_miso (miso)
    );

    ext_spi_master #(.CLK_DIV(1), .GAP(4)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (u_if_b.slave),
        .o_busy (busy_b),
        .o_sck  (sck_b),
        .o_ss_n (ss_n_b),
        .o_mosi (mosi_b),
        .i_miso (miso)
    );

    logic       w_ready, w_busy, w_sck, w_ss_n, w_mosi, w_rsp_valid, w_rsp_err;
    logic [7:0] w_rsp_data;
    assign w_ready     = sel ? u_if_b.req_ready : u_if_a.req_ready;
    assign w_busy      = sel ? busy_b : busy_a;
    assign w_sck       = sel ? sck_b : sck_a;
    assign w_ss_n      = sel ? ss_n_b : ss_n_a;
    assign w_mosi      = sel ? mosi_b : mosi_a;
    assign w_rsp_valid = sel ? u_if_b.rsp_valid : u_if_a.rsp_valid;
    assign w_rsp_data  = sel ? u_if_b.rsp_data : u_if_a.rsp_data;
    assign w_rsp_err   = sel ? u_if_b.rsp_err : u_if_a.rsp_err;

    // CPLD slave model: shifts out {marker, snapshot}, samples mosi on falling SCK,
    // commits a complete frame on the ss_n rise.
    logic [7:0]  m_marker = 8'hEE;
    logic [7:0]  m_snap = 8'h00;
    logic [7:0]  m_fadf = 8'h00;
    logic [7:0]  m_fbdf = 8'h00;
    logic [7:0]  m_ffdf = 8'h00;
    logic        m_wait_n = 1'b1;
    logic [15:0] m_sh = 16'h0000;
    logic [15:0] m_in = 16'h0000;
    logic [15:0] m_last_word = 16'h0000;
    int          m_cnt = 0;
    int          m_rise = 0;

    assign miso = m_sh[15];

    always @(negedge w_ss_n) begin
        m_in   = 16'h0000;
        m_cnt  = 0;
        m_rise = 0;
        m_sh   = {m_marker, m_snap};
    end

    always @(posedge w_sck) if (!w_ss_n) m_rise++;

    always @(negedge w_sck) begin
        if (!w_ss_n) begin
            m_in = {m_in[14:0], w_mosi};
            m_sh = {m_sh[14:0], 1'b0};
            m_cnt++;
        end
    end

    always @(posedge w_ss_n) begin
        if (m_cnt == 16) begin
            m_last_word = m_in;
            case (m_in[10:8])
                3'd0: m_fadf = m_in[7:0];
                3'd1: m_fbdf = m_in[7:0];
                3'd2: m_ffdf = m_in[7:0];
                3'd3: m_wait_n = ~m_in[0];
                default: ;
            endcase
        end
    end

    // Frame timing monitor, sampled mid-cycle
    int  rsp_cnt = 0;
    int  ready_in_frame = 0;
    int  low_run = 0;
    int  high_run = 0;
    int  last_low = 0;
    int  last_high = 0;
    logic ss_prev = 1'b1;

    always @(negedge clk) begin
        if (w_rsp_valid) rsp_cnt++;
        if (!w_ss_n && w_ready) ready_in_frame++;
        if (w_ss_n) begin
            if (!ss_prev) begin
                last_low = low_run;
                high_run = 0;
            end
            high_run++;
        end else begin
            if (ss_prev) begin
                last_high = high_run;
                low_run = 0;
            end
            low_run++;
        end
        ss_prev = w_ss_n;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 3000 && !w_ready; i++) @(negedge clk);
        check({tag, "_ready"}, w_ready, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && !(w_ready && !w_busy); i++) @(negedge clk);
        check({tag, "_idle"}, w_busy, 0);
    endtask

    // Presents one request, returns on the negedge after it was accepted.
    task automatic send(input logic [2:0] r, input logic [7:0] d, input string tag);
        @(negedge clk);
        req_reg   = r;
        req_data  = d;
        req_valid = 1'b1;
        wait_ready(tag);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_acc_ready"}, w_ready, 0);
        check({tag, "_acc_busy"}, w_busy, 1);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", w_ready, 1);
        check("rst_rsp_valid", w_rsp_valid, 0);
        check("rst_rsp_data", w_rsp_data, 8'h00);
        check("rst_rsp_err", w_rsp_err, 0);
        check("rst_busy", w_busy, 0);
        check("rst_sck", w_sck, 0);
        check("rst_ss_n", w_ss_n, 1);
        check("rst_mosi", w_mosi, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write reg0=0xA5, slave returns {EE,3C}
        m_marker = 8'hEE;
        m_snap   = 8'h3C;
        base = rsp_cnt;
        send(3'd0, 8'hA5, "w0");
        wait_idle("w0");
        check("w0_mosi_word", m_last_word, 16'h00A5);
        check("w0_sck_rises", m_rise, 16);
        check("w0_ss_low", last_low, 66);
        check("w0_fadf", m_fadf, 8'hA5);
        check("w0_rsp_pulses", rsp_cnt - base, 1);
        check("w0_rsp_data", w_rsp_data, 8'h3C);
        check("w0_rsp_err", w_rsp_err, 0);

        // Corrupted marker on a no-op read
        m_marker = 8'hEF;
        m_snap   = 8'h5A;
        send(3'd4, 8'h00, "bad");
        wait_idle("bad");
        check("bad_rsp_err", w_rsp_err, 1);
        check("bad_rsp_data", w_rsp_data, 8'h5A);
        check("bad_fadf_kept", m_fadf, 8'hA5);
        m_marker = 8'hEE;

        // Back-to-back with req_valid held high
        base = rsp_cnt;
        ready_in_frame = 0;
        @(negedge clk);
        req_reg   = 3'd1;
        req_data  = 8'h12;
        req_valid = 1'b1;
        wait_ready("b2b1");
        @(posedge clk);
        @(negedge clk);
        req_reg  = 3'd2;
        req_data = 8'hFF;
        check("b2b_ready_low", w_ready, 0);
        wait_ready("b2b2");
        check("b2b_first_rsp_before_second", rsp_cnt - base, 1);
        check("b2b_fbdf", m_fbdf, 8'h12);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle("b2b");
        // GAP=4 high cycles plus the one IDLE cycle before re-accept
        check("b2b_ss_high_gap", last_high, 5);
        check("b2b_ffdf", m_ffdf, 8'hFF);
        check("b2b_rsp_pulses", rsp_cnt - base, 2);
        check("b2b_ready_in_frame", ready_in_frame, 0);

        // Wait hold set then cleared
        send(3'd3, 8'h01, "wt1");
        check("wt1_before_commit", m_wait_n, 1);
        wait_idle("wt1");
        check("wt1_wait_n", m_wait_n, 0);
        send(3'd3, 8'h00, "wt0");
        wait_idle("wt0");
        check("wt0_wait_n", m_wait_n, 1);

        // Reset after the 5th rising SCK edge
        base = rsp_cnt;
        send(3'd0, 8'h3F, "rs");
        for (int i = 0; i < 500 && m_rise < 5; i++) @(negedge clk);
        check("rs_reached_5", m_rise, 5);
        check("rs_sck_high", w_sck, 1);
        rst_n = 1'b0;
        #1;
        check("rs_ss_n", w_ss_n, 1);
        check("rs_sck", w_sck, 0);
        check("rs_mosi", w_mosi, 0);
        check("rs_busy", w_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rs_ready_after", w_ready, 1);
        check("rs_no_rsp", rsp_cnt - base, 0);
        check("rs_fadf_untouched", m_fadf, 8'hA5);

        // Clean frame after reset
        m_snap = 8'h81;
        send(3'd0, 8'h77, "cl");
        wait_idle("cl");
        check("cl_fadf", m_fadf, 8'h77);
        check("cl_sck_rises", m_rise, 16);
        check("cl_ss_low", last_low, 66);
        check("cl_rsp_data", w_rsp_data, 8'h81);

        // CLK_DIV=1 instance, no-op read of reg 5
        @(negedge clk);
        sel = 1'b1;
        m_snap = 8'hC3;
        base = rsp_cnt;
        repeat (2) @(negedge clk);
        send(3'd5, 8'h00, "d1");
        wait_idle("d1");
        check("d1_sck_rises", m_rise, 16);
        check("d1_ss_low", last_low, 33);
        check("d1_mosi_word", m_last_word, 16'h0500);
        check("d1_rsp_pulses", rsp_cnt - base, 1);
        check("d1_rsp_data", w_rsp_data, 8'hC3);
        check("d1_rsp_err", w_rsp_err, 0);
        check("d1_regs_kept", {m_fadf, m_fbdf, m_ffdf}, 24'h7712FF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ext_spi_master.md
Name: ext_spi_master

Overview:
- Host-side SPI master that feeds the card's CPLD SPI slave (the 0xDF port-emulation block).
- Takes single register-write or read requests from the controller fabric and serialises each one as one 16-bit frame.
- Captures the 16-bit word the slave returns: an 0xEE marker byte followed by the snapshot of the Z80 data bus.
- Flags a link error when the marker byte is wrong.

Parameters:
CLK_DIV, 4, clk cycles per SCK half-period (min 1)
GAP, 4, clk cycles ss_n is held high between frames (min 1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_reg  input  3  target register: 0=FADF, 1=FBDF, 2=FFDF, 3=wait control, 4-7=no-op (read only)
req_data  input  8  value to write (bit0 only for reg 3)
rsp_valid  output  1  one-cycle pulse, response fields valid
rsp_data  output  8  Z80 bus snapshot from frame bits 7:0
rsp_err  output  1  frame bits 15:8 were not 0xEE
busy  output  1  frame or gap in progress
sck  output  1  SPI clock, idle low
ss_n  output  1  SPI select, active low
mosi  output  1  master data out
miso  input  1  slave data in

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0x00, rsp_err=0, busy=0, sck=0, ss_n=1, mosi=0.
- Outgoing frame word W = {5'b00000, req_reg, req_data}, sent MSB first.
- Handshake:
  - A request is accepted on a clk edge where req_valid & req_ready; req_reg/req_data are latched on that edge.
  - req_ready=1 only in IDLE.
  - req_ready and busy are registered; both change on the edge after acceptance.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP. A phase counter counts CLK_DIV cycles per phase; bit counter k runs 1..16.
- IDLE: sck=0, ss_n=1. On accept -> SETUP: ss_n=0, mosi=W[15], sck=0, for CLK_DIV cycles.
- HIGH (bit k): sck=1 for CLK_DIV cycles.
  - On entry for k>=2, mosi <= W[16-k], i.e. mosi changes together with the rising SCK edge.
  - The slave samples mosi on the falling edge, so setup time is a full half-period.
- LOW (bit k): sck=0 for CLK_DIV cycles.
  - The falling transition into LOW samples miso into rx[16-k].
  - After LOW with k<16 -> HIGH with k+1. After LOW with k=16 -> GAP.
- Frame timing:
  - Exactly 16 rising and 16 falling SCK edges per frame.
  - ss_n is low for CLK_DIV*33 clk cycles.
  - ss_n rises while sck=0; the slave commits writes on that edge.
- GAP: ss_n=1, sck=0, mosi=0 for GAP cycles, then -> IDLE.
- Response:
  - rsp_valid pulses for 1 cycle on the first cycle of GAP.
  - rsp_data=rx[7:0]; rsp_err=(rx[15:8]!=8'hEE).
  - rsp_data/rsp_err hold until the next response.
- Reg 3 frames set or clear the Z80 WAIT hold. The block does not interpret response content beyond the marker.
- req_valid held during a frame is ignored until IDLE; no request is ever dropped once accepted.
- Reset mid-frame:
  - Outputs go to reset values immediately; ss_n rising early may commit a partial frame at the slave.
  - Software must rewrite affected registers after reset.
  - No rsp_valid is produced for an aborted frame.
- CLK_DIV=1: sck toggles every clk and the block is still correct.

Test Plan:
- CLK_DIV=2, GAP=4, write reg0=0xA5 -> mosi sequence 0000_0000_1010_0101 on falling edges; ss_n low 66 cycles; 16 sck pulses; slave-model FADF=0xA5; rsp_valid 1 cycle.
- Slave model returns {0xEE,0x3C} -> rsp_data=0x3C, rsp_err=0. Corrupted marker 0xEF -> rsp_err=1, rsp_data unchanged in meaning.
- Back-to-back req_valid held high for writes reg1=0x12 and reg2=0xFF -> second accepted only after GAP; ss_n high >=4 cycles between frames; req_ready low throughout the first frame.
- Reg 3 data=0x01, then reg 3 data=0x00 -> slave-model wait_n asserted low after the first frame's ss_n rise, released after the second.
- rst_n asserted after 5th rising SCK edge -> same-cycle ss_n=1, sck=0, mosi=0, req_ready=1 after release; no rsp_valid; next request runs a full clean frame.
- CLK_DIV=1, reg 5 (no-op) read -> 16 sck pulses at clk/2; slave registers unchanged; rsp_data equals the bus snapshot driven by the model.
